bbox_scanner: RTL and testbench

Triangle bounding-box pixel scanner, directly upstream of the barycentric coordinate stage. It accepts one triangle (three vertices) per handshake and computes the axis-aligned bounding box, optionally clipped to the screen. It then emits every pixel position in the box in raster order, with the triangle's vertices held alongside, over a valid/ready handshake. Downstream consumes `p_x`/`p_y` plus the vertices and computes barycentric weights.

---
 rtl/bbox_scanner.sv | 184 ++++++++++++++++++
 tb/tb_bbox_scanner.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bbox_scanner.sv
// Triangle bounding-box raster scanner feeding the barycentric stage.
// Optional scissor clamp to SCREEN_W x SCREEN_H via `SCISSOR_CLIP_EN.
module bbox_scanner #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nd,
    output logic        us_rfd,
    input  logic [15:0] v1_x,
    input  logic [15:0] v1_y,
    input  logic [15:0] v2_x,
    input  logic [15:0] v2_y,
    input  logic [15:0] v3_x,
    input  logic [15:0] v3_y,
    input  logic        ds_rfd,
    output logic        rdy,
    output logic [15:0] p_x,
    output logic [15:0] p_y,
    output logic [15:0] o_v1_x,
    output logic [15:0] o_v1_y,
    output logic [15:0] o_v2_x,
    output logic [15:0] o_v2_y,
    output logic [15:0] o_v3_x,
    output logic [15:0] o_v3_y,
    output logic        last,
    output logic        tri_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BBOX,
        S_SCAN
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_accept;
    logic        w_xfer;
    logic        w_empty;
    logic        w_x_end;
    logic [15:0] r_xmin;
    logic [15:0] r_xmax;
    logic [15:0] r_ymax;
    logic [15:0] w_xmin;
    logic [15:0] w_xmax;
    logic [15:0] w_ymin;
    logic [15:0] w_ymax;
    logic [15:0] w_xmax_c;
    logic [15:0] w_ymax_c;
    logic [15:0] w_px_nxt;
    logic [15:0] w_py_nxt;

    assign us_rfd = (r_state == S_IDLE);
    assign w_xfer = rdy & ds_rfd;

    // Unsigned min/max over the latched vertices
    always_comb begin
        w_xmin = o_v1_x;
        w_xmax = o_v1_x;
        w_ymin = o_v1_y;
        w_ymax = o_v1_y;
        if (o_v2_x < w_xmin) w_xmin = o_v2_x;
        if (o_v3_x < w_xmin) w_xmin = o_v3_x;
        if (o_v2_x > w_xmax) w_xmax = o_v2_x;
        if (o_v3_x > w_xmax) w_xmax = o_v3_x;
        if (o_v2_y < w_ymin) w_ymin = o_v2_y;
        if (o_v3_y < w_ymin) w_ymin = o_v3_y;
        if (o_v2_y > w_ymax) w_ymax = o_v2_y;
        if (o_v3_y > w_ymax) w_ymax = o_v3_y;
    end

`ifdef SCISSOR_CLIP_EN
    localparam logic [15:0] XLIM = 16'(SCREEN_W - 1);
    localparam logic [15:0] YLIM = 16'(SCREEN_H - 1);

    // Clamp the box max to the last on-screen pixel
    always_comb begin
        w_xmax_c = (w_xmax > XLIM) ? XLIM : w_xmax;
        w_ymax_c = (w_ymax > YLIM) ? YLIM : w_ymax;
    end
`else
    logic w_unused_screen;

    assign w_unused_screen = ^{32'(SCREEN_W), 32'(SCREEN_H)};
    assign w_xmax_c = w_xmax;
    assign w_ymax_c = w_ymax;
`endif

    assign w_empty = (w_xmin > w_xmax_c) || (w_ymin > w_ymax_c);

    // Raster step: compare against max first so 0xFFFF never wraps
    always_comb begin
        w_x_end  = (p_x == r_xmax);
        w_px_nxt = w_x_end ? r_xmin : p_x + 16'd1;
        w_py_nxt = w_x_end ? p_y + 16'd1 : p_y;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (nd) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_BBOX;
                end
            end
            S_BBOX: w_state_nxt = w_empty ? S_IDLE : S_SCAN;
            S_SCAN: begin
                if (w_xfer && last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Vertex latch on accept
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_v1_x <= '0;
            o_v1_y <= '0;
            o_v2_x <= '0;
            o_v2_y <= '0;
            o_v3_x <= '0;
            o_v3_y <= '0;
        end else if (w_accept) begin
            o_v1_x <= v1_x;
            o_v1_y <= v1_y;
            o_v2_x <= v2_x;
            o_v2_y <= v2_y;
            o_v3_x <= v3_x;
            o_v3_y <= v3_y;
        end
    end

    // Box registers, pixel walk and handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xmin   <= '0;
            r_xmax   <= '0;
            r_ymax   <= '0;
            p_x      <= '0;
            p_y      <= '0;
            rdy      <= 1'b0;
            last     <= 1'b0;
            tri_done <= 1'b0;
        end else begin
            tri_done <= 1'b0;
            if (r_state == S_BBOX) begin
                r_xmin <= w_xmin;
                r_xmax <= w_xmax_c;
                r_ymax <= w_ymax_c;
                if (w_empty) begin
                    tri_done <= 1'b1;
                end else begin
                    p_x  <= w_xmin;
                    p_y  <= w_ymin;
                    rdy  <= 1'b1;
                    last <= (w_xmin == w_xmax_c) && (w_ymin == w_ymax_c);
                end
            end
            if (w_xfer) begin
                if (last) begin
                    rdy      <= 1'b0;
                    last     <= 1'b0;
                    tri_done <= 1'b1;
                end else begin
                    p_x  <= w_px_nxt;
                    p_y  <= w_py_nxt;
                    last <= (w_px_nxt == r_xmax) && (w_py_nxt == r_ymax);
                end
            end
        end
    end

endmodule

// File: tb/tb_bbox_scanner.sv
// Scoreboard bench for bbox_scanner: directed triangles, backpressure,
// mid-scan reset; clip or full-range cases chosen by `SCISSOR_CLIP_EN.
module tb_bbox_scanner;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        lst;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        nd = 1'b0;
    logic        us_rfd;
    logic [15:0] v1_x = '0, v1_y = '0;
    logic [15:0] v2_x = '0, v2_y = '0;
    logic [15:0] v3_x = '0, v3_y = '0;
    logic        ds_rfd = 1'b1;
    logic        rdy;
    logic [15:0] p_x, p_y;
    logic [15:0] o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y;
    logic        last;
    logic        tri_done;

    beat_t       q[$];
    logic [95:0] cur_v = '0;
    int          n_vec = 0;
    int          n_err = 0;
    int          n_beats = 0;
    int          cyc = 0;
    int          done_due = -1;
    logic        bp_en = 1'b0;
    logic        ds_level = 1'b1;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_x, prev_y;
    logic        prev_last;

    bbox_scanner #(.SCREEN_W(640), .SCREEN_H(480)) dut (
        .clk(clk), .rst(rst), .nd(nd), .us_rfd(us_rfd),
        .v1_x(v1_x), .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
        .v3_x(v3_x), .v3_y(v3_y), .ds_rfd(ds_rfd), .rdy(rdy),
        .p_x(p_x), .p_y(p_y),
        .o_v1_x(o_v1_x), .o_v1_y(o_v1_y), .o_v2_x(o_v2_x),
        .o_v2_y(o_v2_y), .o_v3_x(o_v3_x), .o_v3_y(o_v3_y),
        .last(last), .tri_done(tri_done)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference raster of the (optionally clipped) bounding box
    task automatic push_box(input int ax, input int ay, input int bx,
                            input int by, input int cx, input int cy,
                            output int n);
        int xmn, xmx, ymn, ymx;
        beat_t b;
        xmn = ax; xmx = ax; ymn = ay; ymx = ay;
        if (bx < xmn) xmn = bx;
        if (cx < xmn) xmn = cx;
        if (bx > xmx) xmx = bx;
        if (cx > xmx) xmx = cx;
        if (by < ymn) ymn = by;
        if (cy < ymn) ymn = cy;
        if (by > ymx) ymx = by;
        if (cy > ymx) ymx = cy;
`ifdef SCISSOR_CLIP_EN
        if (xmx > 639) xmx = 639;
        if (ymx > 479) ymx = 479;
`endif
        n = 0;
        for (int y = ymn; y <= ymx; y++) begin
            for (int x = xmn; x <= xmx; x++) begin
                b.x = 16'(x);
                b.y = 16'(y);
                b.lst = (x == xmx) && (y == ymx);
                q.push_back(b);
                n++;
            end
        end
    endtask

    task automatic send(input int ax, input int ay, input int bx,
                        input int by, input int cx, input int cy);
        int k = 0;
        int n;
        while (!us_rfd && k < 200) begin
            @(posedge clk); #1; k++;
        end
        check("idle_wait", us_rfd, 1'b1);
        n_beats = 0;
        v1_x = 16'(ax); v1_y = 16'(ay);
        v2_x = 16'(bx); v2_y = 16'(by);
        v3_x = 16'(cx); v3_y = 16'(cy);
        cur_v = {v1_x, v1_y, v2_x, v2_y, v3_x, v3_y};
        push_box(ax, ay, bx, by, cx, cy, n);
        nd = 1'b1;
        @(posedge clk); #1;
        nd = 1'b0;
        if (n == 0) done_due = cyc + 1;
        @(negedge clk);
        check("bbox_rdy", rdy, 1'b0);
        check("bbox_rfd", us_rfd, 1'b0);
        @(negedge clk);
        check("lat_rdy", rdy, (n != 0));
    endtask

    task automatic wait_done(input string tag, input int exp_beats);
        int k = 0;
        while ((q.size() != 0 || cyc <= done_due || !us_rfd) && k < 500) begin
            @(negedge clk); #1; k++;
        end
        check({tag, "_timeout"}, (k < 500), 1'b1);
        check({tag, "_beats"}, n_beats, exp_beats);
        check({tag, "_qleft"}, q.size(), 0);
    endtask

    // Downstream ready: level or 1,0,0,1 pattern
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                ds_rfd = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                ds_rfd = ds_level;
            end
        end
    end

    // Output monitor: scoreboard pops, stall stability, tri_done timing
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            check("tri_done", tri_done, (cyc == done_due));
            if (tri_done) check("done_rfd", us_rfd, 1'b1);
            if (stall_prev) begin
                check("stall_rdy", rdy, 1'b1);
                check("stall_xy", {p_x, p_y, last}, {prev_x, prev_y, prev_last});
            end
            if (rdy && ds_rfd) begin
                if (q.size() == 0) begin
                    check("extra_beat", {p_x, p_y}, 32'hffffffff);
                end else begin
                    e = q.pop_front();
                    check("pixel", {p_x, p_y, last}, {e.x, e.y, e.lst});
                end
                check("vtx", {o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y},
                      cur_v);
                n_beats++;
                if (last) done_due = cyc + 1;
            end
            stall_prev = rdy && !ds_rfd;
            prev_x = p_x;
            prev_y = p_y;
            prev_last = last;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        int k;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", {rdy, last, tri_done, p_x, p_y}, '0);
        check("rst_vtx", {o_v1_x, o_v1_y, o_v2_x, o_v2_y, o_v3_x, o_v3_y}, '0);
        #2 rst = 1'b1;
        #1 check("rst_rfd", us_rfd, 1'b1);

        // Basic box, nd pulsed again mid-scan must be ignored
        send(2, 3, 5, 3, 2, 4);
        v1_x = 16'd100; v2_x = 16'd200; v3_y = 16'd300;
        nd = 1'b1;
        repeat (3) @(posedge clk);
        #1 nd = 1'b0;
        wait_done("basic", 8);

        // Degenerate point
        send(7, 7, 7, 7, 7, 7);
        wait_done("point", 1);

        // Backpressure on the basic box
        bp_en = 1'b1;
        send(2, 3, 5, 3, 2, 4);
        wait_done("bp", 8);
        bp_en = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SCISSOR_CLIP_EN
        send(638, 10, 700, 10, 638, 11);
        wait_done("clip", 4);
        send(650, 0, 660, 0, 655, 5);
        wait_done("offscr", 0);
`else
        send(16'hfffe, 0, 16'hffff, 0, 16'hffff, 0);
        wait_done("edge", 2);
`endif

        // Reset during beat 3 of the basic box
        send(2, 3, 5, 3, 2, 4);
        k = 0;
        while (n_beats < 2 && k < 50) begin
            @(negedge clk); #1; k++;
        end
        check("beat2_seen", (n_beats >= 2), 1'b1);
        @(posedge clk); #2;
        check("beat3_xy", {p_x, p_y}, {16'd4, 16'd3});
        rst = 1'b0;
        q.delete();
        done_due = -1;
        #1;
        check("mrst_out", {rdy, last, tri_done, p_x, p_y}, '0);
        check("mrst_vtx", {o_v1_x, o_v3_y}, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("mrst_rfd", us_rfd, 1'b1);
        send(10, 20, 11, 20, 10, 21);
        wait_done("post_rst", 4);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
